// File: rtl/lfsr_checker.sv
// Sequence checker for the 64-bit XNOR LFSR test block: predicts each sample
// from the previous one and flags, counts and latches divergence.
module lfsr_checker #(
    parameter int CNT_W     = 16,
    parameter int ERR_W     = 8,
    parameter int LOCK_LEN  = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [63:0]      DATA,
    output logic             LOCKED,
    output logic             MISMATCH,
    output logic             STUCK,
    output logic             FAIL,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [ERR_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {SEED = 2'd0, TRACK = 2'd1, FAILED = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MATCH_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [7:0]       LOCK_V    = 8'(LOCK_LEN);
    localparam logic [ERR_W:0]   LIMIT_V   = (ERR_W+1)'(ERR_LIMIT);

    state_t           state, state_nxt;
    logic [63:0]      prev_p0;
    logic [63:0]      exp_p0;
    logic [7:0]       streak;
    logic [CNT_W-1:0] match_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic             mism_r, stuck_r;
    logic             cmp, hit, miss, trip;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {~(s[0] ^ s[8] ^ s[13] ^ s[31]), s[63:1]};
    endfunction

    assign exp_p0 = lfsr_step(prev_p0);
    assign cmp    = EN && (state == TRACK);
    assign hit    = cmp && (DATA == exp_p0);
    assign miss   = cmp && (DATA != exp_p0);
    // Trip on the mismatch that brings the count up to the limit, judged before saturation.
    assign trip   = miss && (({1'b0, err_cnt} + (ERR_W+1)'(1)) >= LIMIT_V);

    always_ff @(posedge CLK) begin
        if (RST) state <= SEED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEED:    if (EN) state_nxt = TRACK;
            TRACK:   if (trip) state_nxt = FAILED;
            FAILED:  state_nxt = FAILED;
            default: state_nxt = SEED;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_p0   <= '0;
            streak    <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            mism_r    <= 1'b0;
            stuck_r   <= 1'b0;
        end else begin
            mism_r <= miss;
            if (EN && (state == SEED)) prev_p0 <= DATA;
            if (cmp) begin
                // Resync to the new sample whether or not it matched.
                prev_p0 <= DATA;
                stuck_r <= (DATA == '1);
            end
            if (hit) begin
                if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + CNT_W'(1);
                if (streak < LOCK_V)        streak    <= streak + 8'd1;
            end
            if (miss) begin
                if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
                streak <= '0;
            end
        end
    end

    always_comb begin
        LOCKED    = (state == TRACK) && (streak >= LOCK_V);
        FAIL      = (state == FAILED);
        MISMATCH  = mism_r;
        STUCK     = stuck_r;
        MATCH_CNT = match_cnt;
        ERR_CNT   = err_cnt;
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: startup vector table plus scoreboarded sequences
// for corruption, fail latch, lock-up, enable gating and mid-run reset.
module tb_lfsr_checker;

    typedef struct packed {
        logic        locked;
        logic        mism;
        logic        stuck;
        logic        fail;
        logic [15:0] mcnt;
        logic [7:0]  ecnt;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        en;
        logic [63:0] data;
        exp_t        exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST, EN;
    logic [63:0] DATA;
    logic        LOCKED, MISMATCH, STUCK, FAIL;
    logic [15:0] MATCH_CNT;
    logic [7:0]  ERR_CNT;
    logic        locked2, mism2, stuck2, fail2;
    logic [3:0]  mcnt2;
    logic [7:0]  ecnt2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_mism   = 0;

    exp_t sb[$];

    int          m_st, m_streak, m_mc, m_ec;
    logic [63:0] m_prev;
    logic        m_mism, m_stuck;

    always #5 CLK = ~CLK;

    lfsr_checker dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DATA(DATA),
        .LOCKED(LOCKED), .MISMATCH(MISMATCH), .STUCK(STUCK), .FAIL(FAIL),
        .MATCH_CNT(MATCH_CNT), .ERR_CNT(ERR_CNT)
    );

    lfsr_checker #(.CNT_W(4)) dut2 (
        .CLK(CLK), .RST(RST), .EN(EN), .DATA(DATA),
        .LOCKED(locked2), .MISMATCH(mism2), .STUCK(stuck2), .FAIL(fail2),
        .MATCH_CNT(mcnt2), .ERR_CNT(ecnt2)
    );

    function automatic logic [63:0] nxt(input logic [63:0] x);
        return {~(x[0] ^ x[8] ^ x[13] ^ x[31]), x[63:1]};
    endfunction

    function automatic exp_t mk(input int l, input int m, input int s, input int f,
                                input int mc, input int ec);
        exp_t e;
        e.locked = l[0];
        e.mism   = m[0];
        e.stuck  = s[0];
        e.fail   = f[0];
        e.mcnt   = mc[15:0];
        e.ecnt   = ec[7:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    task automatic model(input logic r, input logic e, input logic [63:0] d, output exp_t x);
        logic        fb;
        logic [63:0] pred;
        if (r) begin
            m_st = 0; m_prev = '0; m_streak = 0; m_mc = 0; m_ec = 0;
            m_mism = 1'b0; m_stuck = 1'b0;
        end else begin
            m_mism = 1'b0;
            if (e && m_st == 0) begin
                m_prev = d;
                m_st   = 1;
            end else if (e && m_st == 1) begin
                fb      = ~(m_prev[0] ^ m_prev[8] ^ m_prev[13] ^ m_prev[31]);
                pred    = (m_prev >> 1) | ({63'd0, fb} << 63);
                m_stuck = (d == {64{1'b1}});
                if (d == pred) begin
                    if (m_mc < 65535) m_mc++;
                    if (m_streak < 8) m_streak++;
                end else begin
                    if (m_ec < 255) m_ec++;
                    m_streak = 0;
                    m_mism   = 1'b1;
                    if (m_ec >= 4) m_st = 2;
                end
                m_prev = d;
            end
        end
        x = mk((m_st == 1 && m_streak >= 8) ? 1 : 0, m_mism ? 1 : 0, m_stuck ? 1 : 0,
               (m_st == 2) ? 1 : 0, m_mc, m_ec);
    endtask

    task automatic step(input logic r, input logic e, input logic [63:0] d,
                        input bit use_t, input exp_t te, input string nm);
        exp_t m, got, req;
        model(r, e, d, m);
        sb.push_back(use_t ? te : m);
        RST = r; EN = e; DATA = d;
        @(posedge CLK);
        #1;
        got = {LOCKED, MISMATCH, STUCK, FAIL, MATCH_CNT, ERR_CNT};
        req = sb.pop_front();
        chk(nm, 64'(got), 64'(req));
        if (MISMATCH) n_mism++;
    endtask

    task automatic go(input logic r, input logic e, input logic [63:0] d, input string nm);
        step(r, e, d, 1'b0, exp_t'(0), nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[7];
        logic [63:0] cur, r;
        exp_t        snap, got;
        int          first_lock;

        RST = 1'b1; EN = 1'b0; DATA = '0;
        tbl[0] = '{1'b1, 1'b0, 64'h0,                  mk(0, 0, 0, 0, 0, 0)};
        tbl[1] = '{1'b1, 1'b0, 64'h0,                  mk(0, 0, 0, 0, 0, 0)};
        tbl[2] = '{1'b0, 1'b1, 64'h0,                  mk(0, 0, 0, 0, 0, 0)};
        tbl[3] = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, mk(0, 0, 0, 0, 1, 0)};
        tbl[4] = '{1'b0, 1'b1, 64'hC000_0000_0000_0000, mk(0, 0, 0, 0, 2, 0)};
        tbl[5] = '{1'b0, 1'b1, 64'hE000_0000_0000_0000, mk(0, 0, 0, 0, 3, 0)};
        tbl[6] = '{1'b0, 1'b1, 64'hF000_0000_0000_0000, mk(0, 0, 0, 0, 4, 0)};

        // Normal run: reset, seed with 0, 19 compares in total
        for (int i = 0; i < 7; i++)
            step(tbl[i].rst, tbl[i].en, tbl[i].data, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        cur = 64'hF000_0000_0000_0000;
        first_lock = 0;
        for (int k = 5; k <= 19; k++) begin
            cur = nxt(cur);
            go(1'b0, 1'b1, cur, "c1_seq");
            if (LOCKED && first_lock == 0) first_lock = k;
        end
        chk("c1_match_cnt", 64'(MATCH_CNT), 64'd19);
        chk("c1_err_cnt", 64'(ERR_CNT), 64'd0);
        chk("c1_lock_at", 64'(first_lock), 64'd8);
        chk("c1_no_mismatch", 64'(n_mism), 64'd0);
        chk("c1_sat_cnt4", 64'(mcnt2), 64'd15);
        chk("c1_sat_locked", 64'(locked2), 64'd1);

        // Single corruption at compare 10
        go(1'b1, 1'b0, 64'h0, "c2_rst");
        n_mism = 0;
        cur = '0;
        go(1'b0, 1'b1, cur, "c2_seed");
        for (int k = 1; k <= 9; k++) begin
            cur = nxt(cur);
            go(1'b0, 1'b1, cur, "c2_seq");
        end
        chk("c2_locked_before", 64'(LOCKED), 64'd1);
        cur = nxt(cur) ^ (64'd1 << 5);
        go(1'b0, 1'b1, cur, "c2_corrupt");
        chk("c2_pulse", 64'(MISMATCH), 64'd1);
        chk("c2_lock_drop", 64'(LOCKED), 64'd0);
        for (int k = 1; k <= 9; k++) begin
            cur = nxt(cur);
            go(1'b0, 1'b1, cur, "c2_resync");
            if (k == 7) chk("c2_lock_7", 64'(LOCKED), 64'd0);
            if (k == 8) chk("c2_lock_8", 64'(LOCKED), 64'd1);
        end
        chk("c2_err_cnt", 64'(ERR_CNT), 64'd1);
        chk("c2_one_pulse", 64'(n_mism), 64'd1);

        // Fail latch: four bad samples, then the true sequence is ignored
        go(1'b1, 1'b0, 64'h0, "c3_rst");
        cur = '0;
        go(1'b0, 1'b1, cur, "c3_seed");
        for (int k = 1; k <= 4; k++) begin
            r = {$urandom, $urandom};
            if (r == nxt(cur)) r = ~r;
            cur = r;
            go(1'b0, 1'b1, cur, "c3_rand");
            chk($sformatf("c3_err_%0d", k), 64'(ERR_CNT), 64'(k));
            chk($sformatf("c3_fail_%0d", k), 64'(FAIL), (k == 4) ? 64'd1 : 64'd0);
        end
        chk("c3_last_pulse", 64'(MISMATCH), 64'd1);
        n_mism = 0;
        for (int k = 1; k <= 6; k++) begin
            cur = nxt(cur);
            go(1'b0, 1'b1, cur, "c3_frozen");
        end
        chk("c3_err_frozen", 64'(ERR_CNT), 64'd4);
        chk("c3_match_frozen", 64'(MATCH_CNT), 64'd0);
        chk("c3_fail_held", 64'(FAIL), 64'd1);
        chk("c3_no_pulse", 64'(n_mism), 64'd0);
        go(1'b1, 1'b1, cur, "c3_rst_clear");
        chk("c3_fail_cleared", 64'(FAIL), 64'd0);

        // Lock-up: all-ones maps onto itself
        for (int k = 0; k < 10; k++) go(1'b0, 1'b1, {64{1'b1}}, "c4_ones");
        chk("c4_match_cnt", 64'(MATCH_CNT), 64'd9);
        chk("c4_stuck", 64'(STUCK), 64'd1);
        chk("c4_locked", 64'(LOCKED), 64'd1);

        // Enable gating with junk on DATA
        go(1'b1, 1'b0, 64'h0, "c5_rst");
        cur = '0;
        go(1'b0, 1'b1, cur, "c5_seed");
        for (int k = 1; k <= 10; k++) begin
            cur = nxt(cur);
            go(1'b0, 1'b1, cur, "c5_seq");
        end
        snap = {LOCKED, MISMATCH, STUCK, FAIL, MATCH_CNT, ERR_CNT};
        for (int k = 0; k < 5; k++) begin
            go(1'b0, 1'b0, {$urandom, $urandom}, "c5_gated");
            got = {LOCKED, MISMATCH, STUCK, FAIL, MATCH_CNT, ERR_CNT};
            chk("c5_hold", 64'(got), 64'(snap));
        end
        cur = nxt(cur);
        go(1'b0, 1'b1, cur, "c5_resume");
        chk("c5_resume_cnt", 64'(MATCH_CNT), 64'd11);
        chk("c5_resume_nomism", 64'(MISMATCH), 64'd0);

        // Reset while locked with two errors recorded
        go(1'b1, 1'b0, 64'h0, "c6_rst");
        cur = '0;
        go(1'b0, 1'b1, cur, "c6_seed");
        for (int k = 0; k < 2; k++) begin
            cur = nxt(cur) ^ 64'h1;
            go(1'b0, 1'b1, cur, "c6_bad");
        end
        for (int k = 0; k < 9; k++) begin
            cur = nxt(cur);
            go(1'b0, 1'b1, cur, "c6_seq");
        end
        chk("c6_pre_locked", 64'(LOCKED), 64'd1);
        chk("c6_pre_err", 64'(ERR_CNT), 64'd2);
        go(1'b1, 1'b1, nxt(cur), "c6_rst_edge");
        got = {LOCKED, MISMATCH, STUCK, FAIL, MATCH_CNT, ERR_CNT};
        chk("c6_reset_vals", 64'(got), 64'd0);
        go(1'b0, 1'b1, 64'h1234, "c6_reseed");
        got = {LOCKED, MISMATCH, STUCK, FAIL, MATCH_CNT, ERR_CNT};
        chk("c6_reseed_nocmp", 64'(got), 64'd0);
        go(1'b0, 1'b1, nxt(64'h1234), "c6_first_cmp");
        chk("c6_first_match", 64'(MATCH_CNT), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
